// File: rtl/game_sequencer_pkg.sv
// Shared types and default timing constants for the flappy game.
// Used by the sequencer, its tick dividers and the bird/pipe blocks.
package game_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_OVER
  } game_state_t;

  localparam int LEVEL_MAX          = 15;
  localparam int PERIOD_W_DEF       = 10;
  localparam int BIRD_PERIOD_DEF    = 192;
  localparam int PIPE_PERIOD_INIT_D = 384;
  localparam int PIPE_PERIOD_MIN_D  = 128;
  localparam int PERIOD_STEP_DEF    = 32;
  localparam int SPEEDUP_POINTS_DEF = 4;
  localparam int SPAWN_GAP_DEF      = 3;
  localparam int OVER_HOLD_DEF      = 256;

endpackage

// File: rtl/game_sequencer_if.sv
// Player/collision inputs and sequencing outputs of the game controller.
// master: drives press/collide/point; slave: the sequencer itself.
interface game_sequencer_if #(
  parameter int PERIOD_W = 10
);

  logic                press;
  logic                collide;
  logic                point;
  logic                start;
  logic                over;
  logic                bird_tick;
  logic                pipe_tick;
  logic                spawn;
  logic [PERIOD_W-1:0] pipe_period;
  logic [3:0]          level;

  modport master (
    output press, collide, point,
    input  start, over, bird_tick,
    input  pipe_tick, spawn,
    input  pipe_period, level
  );

  modport slave (
    input  press, collide, point,
    output start, over, bird_tick,
    output pipe_tick, spawn,
    output pipe_period, level
  );

endinterface

// File: rtl/game_sequencer_tick_divider.sv
// Period counter emitting a registered one-cycle tick every i_period cycles.
// Ports: i_clk, i_reset (sync, active-low), i_period, i_clr, i_en, o_wrap, o_tick.
module tick_divider #(
  parameter int PERIOD_W = 10
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_clr,
  input  logic                i_en,
  output logic                o_wrap,
  output logic                o_tick
);

  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W:0]   w_cnt_inc;

  assign w_cnt_inc = {1'b0, r_cnt} + (PERIOD_W+1)'(1);

  // >= rather than == so a period that shrinks below the
  // current count wraps at once instead of running on.
  assign o_wrap = i_en && !i_clr &&
                  (w_cnt_inc >= {1'b0, i_period});

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt  <= '0;
      o_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      o_tick <= 1'b0;
    end else if (o_wrap) begin
      r_cnt  <= '0;
      o_tick <= 1'b1;
    end else if (i_en) begin
      r_cnt  <= w_cnt_inc[PERIOD_W-1:0];
      o_tick <= 1'b0;
    end else begin
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Central IDLE/PLAY/OVER controller: ticks, pipe spawn and difficulty.
// Ports: i_clk, i_reset (sync, active-low), bus (game_sequencer_if.slave).
module game_sequencer
  import game_pkg::*;
#(
  parameter int PERIOD_W         = PERIOD_W_DEF,
  parameter int BIRD_PERIOD      = BIRD_PERIOD_DEF,
  parameter int PIPE_PERIOD_INIT = PIPE_PERIOD_INIT_D,
  parameter int PIPE_PERIOD_MIN  = PIPE_PERIOD_MIN_D,
  parameter int PERIOD_STEP      = PERIOD_STEP_DEF,
  parameter int SPEEDUP_POINTS   = SPEEDUP_POINTS_DEF,
  parameter int SPAWN_GAP        = SPAWN_GAP_DEF,
  parameter int OVER_HOLD        = OVER_HOLD_DEF
) (
  input logic             i_clk,
  input logic             i_reset,
  game_sequencer_if.slave bus
);

  localparam int SW = (SPAWN_GAP > 1)
                    ? $clog2(SPAWN_GAP) : 1;
  localparam int PW = (SPEEDUP_POINTS > 1)
                    ? $clog2(SPEEDUP_POINTS) : 1;
  localparam int HW = (OVER_HOLD > 1)
                    ? $clog2(OVER_HOLD) : 1;

  game_state_t         r_state;
  logic                r_start;
  logic                r_over;
  logic                r_spawn;
  logic [SW-1:0]       r_spawn_cnt;
  logic [PW-1:0]       r_pt_cnt;
  logic [HW-1:0]       r_hold_cnt;
  logic [PERIOD_W-1:0] r_pipe_period;
  logic [3:0]          r_level;

  logic                w_play;
  logic                w_run;
  logic                w_flap;
  logic                w_held;
  logic                w_bird_tick;
  logic                w_pipe_tick;
  logic                w_pipe_wrap;
  logic                w_bird_wrap_unused;
  logic [PERIOD_W:0]   w_pp_sub;
  logic [PERIOD_W-1:0] w_pp_next;

  assign w_play = (r_state == S_PLAY);
  // collide outranks everything else while playing
  assign w_run  = w_play && !bus.collide;
  assign w_flap = w_run && bus.press;
  assign w_held = (r_hold_cnt == HW'(OVER_HOLD - 1));

  // one extra bit so the step can never wrap below zero
  assign w_pp_sub = {1'b0, r_pipe_period}
                  - (PERIOD_W+1)'(PERIOD_STEP);
  assign w_pp_next =
    (w_pp_sub[PERIOD_W] ||
     w_pp_sub < (PERIOD_W+1)'(PIPE_PERIOD_MIN))
    ? PERIOD_W'(PIPE_PERIOD_MIN)
    : w_pp_sub[PERIOD_W-1:0];

  // a flap restarts the gravity phase and eats that tick
  tick_divider #(.PERIOD_W(PERIOD_W)) u_bird (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_period (PERIOD_W'(BIRD_PERIOD)),
    .i_clr    (!w_play || w_flap),
    .i_en     (w_run),
    .o_wrap   (w_bird_wrap_unused),
    .o_tick   (w_bird_tick)
  );

  tick_divider #(.PERIOD_W(PERIOD_W)) u_pipe (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_period (r_pipe_period),
    .i_clr    (!w_play),
    .i_en     (w_run),
    .o_wrap   (w_pipe_wrap),
    .o_tick   (w_pipe_tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= S_IDLE;
      r_start       <= 1'b0;
      r_over        <= 1'b0;
      r_spawn       <= 1'b0;
      r_spawn_cnt   <= '0;
      r_pt_cnt      <= '0;
      r_hold_cnt    <= '0;
      r_pipe_period <= PERIOD_W'(PIPE_PERIOD_INIT);
      r_level       <= '0;
    end else begin
      r_spawn <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_spawn_cnt <= '0;
          r_pt_cnt    <= '0;
          if (bus.press) begin
            r_state <= S_PLAY;
            r_start <= 1'b1;
          end
        end
        S_PLAY: begin
          if (bus.collide) begin
            r_state    <= S_OVER;
            r_start    <= 1'b0;
            r_over     <= 1'b1;
            r_hold_cnt <= '0;
          end else begin
            // spawn rides on the pipe tick that lands on slot 0
            if (w_pipe_wrap) begin
              r_spawn <= (r_spawn_cnt == '0);
              r_spawn_cnt <=
                (r_spawn_cnt == SW'(SPAWN_GAP - 1))
                ? '0 : r_spawn_cnt + 1'b1;
            end
            if (bus.point) begin
              if (r_pt_cnt == PW'(SPEEDUP_POINTS - 1)) begin
                r_pt_cnt      <= '0;
                r_pipe_period <= w_pp_next;
                if (r_level != 4'(LEVEL_MAX))
                  r_level <= r_level + 4'd1;
              end else begin
                r_pt_cnt <= r_pt_cnt + 1'b1;
              end
            end
          end
        end
        S_OVER: begin
          if (!w_held) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end else if (bus.press) begin
            r_state       <= S_IDLE;
            r_over        <= 1'b0;
            r_level       <= '0;
            r_pipe_period <= PERIOD_W'(PIPE_PERIOD_INIT);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_start <= 1'b0;
          r_over  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start       = r_start;
  assign bus.over        = r_over;
  assign bus.bird_tick   = w_bird_tick;
  assign bus.pipe_tick   = w_pipe_tick;
  assign bus.spawn       = r_spawn;
  assign bus.pipe_period = r_pipe_period;
  assign bus.level       = r_level;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: reference model predicts outputs
// per cycle, a separate monitor compares them after each clock edge.
module tb_game_sequencer;

  localparam int BP   = 4;
  localparam int PI   = 8;
  localparam int PMIN = 4;
  localparam int STEP = 2;
  localparam int SP   = 2;
  localparam int GAP  = 3;
  localparam int HOLD = 5;

  typedef struct packed {
    logic       start;
    logic       over;
    logic       bt;
    logic       pt;
    logic       spawn;
    logic [9:0] pp;
    logic [3:0] lvl;
  } exp_t;

  logic clk;
  logic rst_n;
  game_sequencer_if #(.PERIOD_W(10)) bus ();

  game_sequencer #(
    .PERIOD_W         (10),
    .BIRD_PERIOD      (BP),
    .PIPE_PERIOD_INIT (PI),
    .PIPE_PERIOD_MIN  (PMIN),
    .PERIOD_STEP      (STEP),
    .SPEEDUP_POINTS   (SP),
    .SPAWN_GAP        (GAP),
    .OVER_HOLD        (HOLD)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cyc   = 0;

  // reference model: 0 idle, 1 play, 2 over
  int m_mode   = 0;
  int m_bird   = 0;
  int m_pipe   = 0;
  int m_nticks = 0;
  int m_pts    = 0;
  int m_level  = 0;
  int m_period = PI;
  int m_cyc    = 0;
  int m_over_at = 0;

  task automatic step(input bit p, input bit c,
                      input bit pt, input bit r = 1'b1);
    exp_t e;
    e = '0;
    bus.press   = p;
    bus.collide = c;
    bus.point   = pt;
    rst_n       = r;
    m_cyc++;
    if (!r) begin
      m_mode   = 0;
      m_level  = 0;
      m_period = PI;
    end else if (m_mode == 0) begin
      if (p) begin
        m_mode = 1;
        m_bird = 0;
        m_pipe = 0;
        m_nticks = 0;
        m_pts  = 0;
      end
    end else if (m_mode == 1) begin
      if (c) begin
        m_mode    = 2;
        m_over_at = m_cyc;
      end else begin
        if (p) begin
          m_bird = 0;
        end else begin
          m_bird++;
          if (m_bird == BP) begin
            e.bt   = 1'b1;
            m_bird = 0;
          end
        end
        m_pipe++;
        if (m_pipe >= m_period) begin
          e.pt    = 1'b1;
          e.spawn = (m_nticks % GAP) == 0;
          m_nticks++;
          m_pipe  = 0;
        end
        if (pt) begin
          m_pts++;
          if (m_pts == SP) begin
            m_pts    = 0;
            m_level  = (m_level < 15) ? m_level + 1 : 15;
            m_period = (m_period - STEP < PMIN)
                     ? PMIN : m_period - STEP;
          end
        end
      end
    end else begin
      if (p && (m_cyc - m_over_at) >= HOLD) begin
        m_mode   = 0;
        m_level  = 0;
        m_period = PI;
      end
    end
    e.start = (m_mode == 1);
    e.over  = (m_mode == 2);
    e.pp    = 10'(m_period);
    e.lvl   = 4'(m_level);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  // monitor: one expectation per clock edge
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge clk);
      #2;
      n_cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        g.start = bus.start;
        g.over  = bus.over;
        g.bt    = bus.bird_tick;
        g.pt    = bus.pipe_tick;
        g.spawn = bus.spawn;
        g.pp    = bus.pipe_period;
        g.lvl   = bus.level;
        n_tests++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL cyc%0d outputs got st%b ov%b bt%b pt%b sp%b pp%0d lv%0d want st%b ov%b bt%b pt%b sp%b pp%0d lv%0d",
                   n_cyc, g.start, g.over, g.bt, g.pt, g.spawn, g.pp, g.lvl,
                   e.start, e.over, e.bt, e.pt, e.spawn, e.pp, e.lvl);
        end
      end
    end
  end

  initial begin
    int guard;
    bit p, c, pt, r;
    bus.press   = 1'b0;
    bus.collide = 1'b0;
    bus.point   = 1'b0;
    rst_n       = 1'b0;

    // reset, then start and free-run through seven pipe ticks
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    idle(2);
    step(1, 0, 0);
    idle(60);

    // flap exactly when the bird phase is about to wrap
    guard = 0;
    while (m_bird != BP - 1 && guard < 10) begin
      step(0, 0, 0);
      guard++;
    end
    step(1, 0, 0);
    idle(9);

    // period drop while pipe count sits past the new limit
    step(0, 0, 1);
    guard = 0;
    while (m_pipe != 6 && guard < 20) begin
      step(0, 0, 0);
      guard++;
    end
    step(0, 0, 1);
    idle(3);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1);
      idle(2);
    end
    idle(12);

    // collide and point together, then the over hold
    step(0, 1, 1);
    idle(1);
    step(1, 0, 0);
    idle(2);
    step(1, 0, 0);
    idle(2);
    step(1, 0, 0);
    idle(5);

    // reach level 2, then reset mid-game
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    idle(3);
    step(0, 0, 0, 0);
    idle(3);

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      p  = ($urandom_range(0, 6) == 0);
      c  = ($urandom_range(0, 60) == 0);
      pt = ($urandom_range(0, 4) == 0);
      r  = ($urandom_range(0, 500) != 0);
      step(p, c, pt, r);
    end
    idle(4);

    repeat (3) @(posedge clk);
    #3;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Central game controller for the LED-matrix flappy game, clocked on the divided game clock.
- Owns the IDLE/PLAY/OVER state machine and generates the single-cycle tick enables that pace the bird column (gravity) and the pipe scroller.
- Also generates the pipe-spawn request and a difficulty ramp that shortens the pipe period as points accrue.
- Replaces the scattered start/over handling in the bird, pipe and score blocks with one sequencing point.

Parameters:
- PERIOD_W, 10, width of all period counters.
- BIRD_PERIOD, 192, game-clock cycles between bird_tick pulses.
- PIPE_PERIOD_INIT, 384, initial cycles between pipe_tick pulses.
- PIPE_PERIOD_MIN, 128, floor for pipe period.
- PERIOD_STEP, 32, period decrement per level-up.
- SPEEDUP_POINTS, 4, points per level-up (>=1).
- SPAWN_GAP, 3, pipe_ticks per spawn (>=1).
- OVER_HOLD, 256, cycles in OVER before press is accepted.

Ports:
- clk  in  1  game clock
- reset  in  1  synchronous, active-low (0 = reset); single clock domain
- press  in  1  one-cycle pulse, debounced player key
- collide  in  1  level, bird/pipe collision from collision checker
- point  in  1  one-cycle pulse, pipe passed
- start  out  1  high while in PLAY
- over  out  1  high while in OVER
- bird_tick  out  1  one-cycle gravity step enable
- pipe_tick  out  1  one-cycle pipe shift enable
- spawn  out  1  one-cycle new-pipe request, only coincident with pipe_tick
- pipe_period  out  PERIOD_W  current pipe period
- level  out  4  difficulty level

Behaviour:
- All outputs registered. reset==0 at posedge: state IDLE; start/over/bird_tick/pipe_tick/spawn=0; all counters 0; pipe_period=PIPE_PERIOD_INIT; level=0. Reset overrides everything, mid-game included.
- IDLE:
  - Ticks 0.
  - press -> PLAY; start=1 from the next cycle.
  - On entry to PLAY: bird_cnt, pipe_cnt, spawn_cnt, pt_cnt = 0.
- PLAY bird counter:
  - bird_cnt increments each cycle and wraps at BIRD_PERIOD-1.
  - bird_tick=1 in the cycle after bird_cnt==BIRD_PERIOD-1 was sampled.
  - press in PLAY clears bird_cnt to 0 and suppresses that cycle's bird_tick (flap restarts gravity phase).
- PLAY pipe counter:
  - pipe_cnt increments each cycle.
  - When pipe_cnt >= pipe_period-1: pipe_cnt <= 0 and pipe_tick=1 next cycle. The >= compare makes a period shrink take effect immediately without overrun.
  - spawn_cnt counts pipe_ticks modulo SPAWN_GAP; spawn=1 together with the pipe_tick issued while spawn_cnt==0. The first pipe_tick of a game always spawns.
- Points and difficulty:
  - Each point increments pt_cnt.
  - When pt_cnt==SPEEDUP_POINTS-1 and point: pt_cnt <= 0; level <= level+1, saturating at 15; pipe_period <= max(pipe_period-PERIOD_STEP, PIPE_PERIOD_MIN).
  - Subtraction is done at PERIOD_W+1 bits so it cannot underflow.
- Collision:
  - collide sampled high in PLAY -> OVER next cycle.
  - Same-cycle point is dropped, and press is ignored.
  - No tick or spawn is issued in the cycle after collide is sampled.
- OVER:
  - over=1, start=0, all ticks 0.
  - hold_cnt counts to OVER_HOLD-1; press is ignored until hold_cnt saturates.
  - Then press -> IDLE, with level=0 and pipe_period=PIPE_PERIOD_INIT restored on that transition.
  - collide and point are ignored in OVER and IDLE.
- Simultaneous events in PLAY: collide > point; press and bird wrap in the same cycle -> press wins, no tick.
- Latency: press to start = 1 cycle; collide to over = 1 cycle.

Decomposition:
- Package game_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} game_state_t
  - LEVEL_MAX = 15
  - default period constants shared with the pipe and bird blocks.
- One sub-module, tick_divider: period counter with PERIOD_W period input, clear and enable inputs, and a registered tick output, with the >= compare.
  - Instantiated twice: bird (constant period) and pipe (pipe_period).

Test Plan:
Bench parameters: BIRD_PERIOD=4, PIPE_PERIOD_INIT=8, PIPE_PERIOD_MIN=4, PERIOD_STEP=2, SPEEDUP_POINTS=2, SPAWN_GAP=3, OVER_HOLD=5.
1. Reset and start: hold reset=0 for 3 cycles -> all outputs 0, pipe_period=8. Release, pulse press -> start=1 one cycle later; bird_tick every 4 cycles; pipe_tick every 8 cycles; spawn on pipe_ticks 1, 4, 7.
2. Flap phase reset: in PLAY, press on the cycle bird_cnt==3 -> no bird_tick next cycle; next bird_tick 4 cycles after the press.
3. Difficulty ramp: 2 point pulses -> level=1, pipe_period=6. 4 more -> level=3, pipe_period=4. 2 more -> level=4, pipe_period stays 4. Pulse point when pipe_cnt=6 and the period drops to 6 -> pipe_tick next cycle.
4. Collision priority: assert collide and point in the same cycle -> over=1 next cycle, level unchanged, no ticks thereafter.
5. Over hold: press 2 cycles after entering OVER -> ignored. press after 5 cycles -> IDLE, level=0, pipe_period=8. Another press -> PLAY.
6. Mid-game reset: reset=0 during PLAY with level=2 -> next cycle IDLE, all outputs at reset values.
